// File: rtl/ifft16_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly, span 8, for the 16-point section of the 32-point IFFT.
// Difference branch is rotated by W32^(2k) fetched from an external combinational twiddle ROM.
module ifft16_sdf_stage #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_real,
    input  logic signed [W-1:0] in_imag,
    output logic [2:0]          tf_addr,
    input  logic signed [11:0]  tf_real,
    input  logic signed [11:0]  tf_imag,
    output logic                out_valid,
    output logic                out_sop,
    output logic signed [W:0]   out_real,
    output logic signed [W:0]   out_imag
);

    localparam int PW = W + 14;
    localparam logic signed [PW-1:0] SAT_MAX  = {{14{1'b0}}, {W{1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN  = {{14{1'b1}}, {W{1'b0}}};
    localparam logic signed [PW-1:0] HALF_LSB = PW'(512);

    logic [3:0]        cnt;
    logic              primed;
    logic signed [W:0] dl_re [8];
    logic signed [W:0] dl_im [8];

    logic signed [W:0]    a_re, a_im, b_re, b_im;
    logic signed [W:0]    sum_re, sum_im, dif_re, dif_im;
    logic signed [W:0]    tw_re, tw_im;
    logic signed [PW-1:0] p_re, p_im;

    // Q10 product back to sample scale: +0.5 LSB bias, floor shift, clamp to W+1 bits.
    function automatic logic signed [W:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + HALF_LSB) >>> 10;
        if (r > SAT_MAX)
            round_sat = SAT_MAX[W:0];
        else if (r < SAT_MIN)
            round_sat = SAT_MIN[W:0];
        else
            round_sat = r[W:0];
    endfunction

    assign tf_addr = cnt[2:0];

    always_comb begin
        a_re   = dl_re[7];
        a_im   = dl_im[7];
        b_re   = {in_real[W-1], in_real};
        b_im   = {in_imag[W-1], in_imag};
        sum_re = a_re + b_re;
        sum_im = a_im + b_im;
        dif_re = a_re - b_re;
        dif_im = a_im - b_im;
        p_re   = PW'(a_re) * PW'(tf_real) - PW'(a_im) * PW'(tf_imag);
        p_im   = PW'(a_re) * PW'(tf_imag) + PW'(a_im) * PW'(tf_real);
        tw_re  = round_sat(p_re);
        tw_im  = round_sat(p_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            if (in_valid) begin
                cnt <= cnt + 4'd1;
                if (cnt == 4'd7)
                    primed <= 1'b1;
                for (int unsigned i = 1; i < 8; i++) begin
                    dl_re[i] <= dl_re[i-1];
                    dl_im[i] <= dl_im[i-1];
                end
                if (!cnt[3]) begin
                    // First half: store the sample, drain last frame's rotated differences.
                    dl_re[0] <= b_re;
                    dl_im[0] <= b_im;
                    if (primed) begin
                        out_valid <= 1'b1;
                        out_real  <= tw_re;
                        out_imag  <= tw_im;
                    end
                end else begin
                    dl_re[0]  <= dif_re;
                    dl_im[0]  <= dif_im;
                    out_valid <= 1'b1;
                    out_sop   <= (cnt[2:0] == 3'd0);
                    out_real  <= sum_re;
                    out_imag  <= sum_im;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft16_sdf_stage.sv
// Self-checking bench for ifft16_sdf_stage: directed tables, hand sequences and a frame-level reference model.
module tb_ifft16_sdf_stage;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic signed [W-1:0] in_real, in_imag;
    logic [2:0]          tf_addr;
    logic signed [11:0]  tf_real, tf_imag;
    logic                out_valid, out_sop;
    logic signed [W:0]   out_real, out_imag;

    int n_chk  = 0;
    int n_fail = 0;

    // floor(1024*cos(pi*k/8)), floor(-1024*sin(pi*k/8))
    int rom_r [8] = '{1024, 946, 724, 391, 0, -392, -725, -947};
    int rom_i [8] = '{0, -392, -725, -947, -1024, -947, -725, -392};

    assign tf_real = 12'(rom_r[tf_addr]);
    assign tf_imag = 12'(rom_i[tf_addr]);

    always #5 clk = ~clk;

    ifft16_sdf_stage #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag),
        .tf_addr(tf_addr), .tf_real(tf_real), .tf_imag(tf_imag),
        .out_valid(out_valid), .out_sop(out_sop),
        .out_real(out_real), .out_imag(out_imag)
    );

    // Frame-level model: first-half samples, previous frame's differences, position in frame.
    int xr [8], xi [8], dr [8], di [8];
    int pos, nacc, last_re, last_im;

    typedef struct {
        int v; int re; int im;
        int ev; int esop; int er; int ei;
    } vec_t;
    vec_t tbl [24];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int round_sat(input longint p);
        longint q, r;
        q = p + 512;
        r = q / 1024;
        if ((q % 1024) < 0) r = r - 1;
        if (r > 65535) r = 65535;
        if (r < -65536) r = -65536;
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            xr[i] = 0; xi[i] = 0; dr[i] = 0; di[i] = 0;
        end
        pos = 0; nacc = 0; last_re = 0; last_im = 0;
    endtask

    task automatic apply(input int v, input int re, input int im,
                         input int ev, input int esop, input int er, input int ei);
        in_valid = (v != 0);
        in_real  = W'(re);
        in_imag  = W'(im);
        @(negedge clk);
        chk("out_valid", out_valid, ev);
        chk("out_sop", out_sop, (ev != 0) ? esop : 0);
        if (ev != 0) begin
            last_re = er;
            last_im = ei;
        end
        chk("out_real", out_real, last_re);
        chk("out_imag", out_imag, last_im);
    endtask

    task automatic model_apply(input int v, input int re, input int im);
        int ev = 0, esop = 0, er = 0, ei = 0, k;
        if (v != 0) begin
            if (pos < 8) begin
                ev = (nacc >= 8) ? 1 : 0;
                er = round_sat(longint'(dr[pos]) * rom_r[pos] - longint'(di[pos]) * rom_i[pos]);
                ei = round_sat(longint'(dr[pos]) * rom_i[pos] + longint'(di[pos]) * rom_r[pos]);
                xr[pos] = re;
                xi[pos] = im;
            end else begin
                k    = pos - 8;
                ev   = 1;
                esop = (k == 0) ? 1 : 0;
                er   = xr[k] + re;
                ei   = xi[k] + im;
                dr[k] = xr[k] - re;
                di[k] = xi[k] - im;
            end
            pos = (pos + 1) % 16;
            if (nacc < 8) nacc++;
        end
        apply(v, re, im, ev, esop, er, ei);
    endtask

    task automatic reset_check();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int exp_re [8] = '{1000, 924, 707, 382, 0, -383, -708, -925};
        int exp_im [8] = '{0, -383, -708, -925, -1000, -925, -708, -383};
        int r, s;

        rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
        model_reset();
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_out_real", out_real, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Twiddle rounding: zeros, then (-1000,0) x8, then flush zeros.
        for (int i = 0; i < 24; i++) begin
            if (i < 8)
                tbl[i] = '{1, 0, 0, 0, 0, 0, 0};
            else if (i < 16)
                tbl[i] = '{1, -1000, 0, 1, (i == 8) ? 1 : 0, -1000, 0};
            else
                tbl[i] = '{1, 0, 0, 1, 0, exp_re[i-16], exp_im[i-16]};
        end
        for (int i = 0; i < 24; i++)
            apply(tbl[i].v, tbl[i].re, tbl[i].im, tbl[i].ev, tbl[i].esop, tbl[i].er, tbl[i].ei);

        // Same stimulus with random idle cycles: identical values, no strobe after idles.
        reset_check();
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) apply(0, 0, 0, 0, 0, 0, 0);
            apply(tbl[i].v, tbl[i].re, tbl[i].im, tbl[i].ev, tbl[i].esop, tbl[i].er, tbl[i].ei);
        end

        // Saturation of the rotated difference.
        reset_check();
        for (int i = 0; i < 8; i++) model_apply(1, -32768, -32768);
        for (int i = 0; i < 8; i++) begin
            model_apply(1, 32767, 32767);
            if (i == 0) begin
                chk("sat_sum_re", out_real, -1);
                chk("sat_sum_im", out_imag, -1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            model_apply(1, 0, 0);
            if (i == 1) begin
                chk("sat_k1_re", out_real, -65536);
                chk("sat_k1_im", out_imag, -35455);
            end
        end

        // Constant input then impulse, back to back.
        reset_check();
        for (int i = 0; i < 16; i++) begin
            model_apply(1, 100, 0);
            if (i == 8) chk("const_sum_re", out_real, 200);
        end
        model_apply(1, 100, 0);
        for (int i = 1; i < 24; i++) begin
            model_apply(1, 0, 0);
            if (i == 8) chk("impulse_sum_re", out_real, 100);
            if (i == 16) chk("impulse_d0_re", out_real, 100);
        end

        // Random traffic with a mid-frame reset part way through.
        reset_check();
        for (int i = 0; i < 700; i++) begin
            if (i == 347) reset_check();
            r = int'($urandom_range(0, 65535)) - 32768;
            s = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 9) == 0) begin
                r = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                s = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            end
            model_apply(($urandom_range(0, 3) != 0) ? 1 : 0, r, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
